// File: rtl/led_frame_sequencer_pkg.sv
// Shared types and constants for the LED frame sequencer (package led_seq_pkg).
// scale_chan is only instantiated when LEDSEQ_DIM_EN is defined.
package led_seq_pkg;

  localparam int PIXEL_W         = 24;
  localparam int WORDS_PER_PIXEL = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    CAP0,
    RD1,
    CAP1,
    SEND,
    WAIT,
    LATCH
  } seq_state_t;

  // (c * (b + 1)) >> 8 in 16 bits; b = 255 is the identity.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Frame request, SPRAM read port and led_driver handshake of the sequencer.
// LEDSEQ_DIM_EN adds the brightness input.
interface led_frame_sequencer_if #(
  parameter int ADDR_W = 14
);
  import led_seq_pkg::*;

  logic               frame_req;
  logic [ADDR_W-1:0]  frame_base;
  logic               frame_busy;
  logic               frame_done;
  logic               frame_err;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_en;
  logic [15:0]        mem_rdata;
  logic               led_start;
  logic [PIXEL_W-1:0] led_rgb;
  logic               led_done;
`ifdef LEDSEQ_DIM_EN
  logic [7:0]         brightness;

  // master: the sequencer; slave: requester, SPRAM and driver side
  modport master (
    input  frame_req, frame_base, mem_rdata, led_done, brightness,
    output frame_busy, frame_done, frame_err, mem_addr, mem_rd_en, led_start, led_rgb
  );
  modport slave (
    output frame_req, frame_base, mem_rdata, led_done, brightness,
    input  frame_busy, frame_done, frame_err, mem_addr, mem_rd_en, led_start, led_rgb
  );
`else
  modport master (
    input  frame_req, frame_base, mem_rdata, led_done,
    output frame_busy, frame_done, frame_err, mem_addr, mem_rd_en, led_start, led_rgb
  );
  modport slave (
    output frame_req, frame_base, mem_rdata, led_done,
    input  frame_busy, frame_done, frame_err, mem_addr, mem_rd_en, led_start, led_rgb
  );
`endif

endinterface

// File: rtl/led_frame_sequencer_timer.sv
// led_seq_timer: loadable down-counter with zero flag, shared by the
// per-pixel done timeout and the post-frame latch gap.
module led_seq_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer: fetches NUM_LEDS two-word pixels from SPRAM and feeds them
// to led_driver, then idles for the latch gap. Optional dimming: LEDSEQ_DIM_EN.
//
// state | meaning
// IDLE  | waiting for frame_req
// RD0   | read strobe for word 0 of the pixel
// CAP0  | capture word 0 (R,G)
// RD1   | read strobe for word 1
// CAP1  | capture word 1 low byte (B), form led_rgb
// SEND  | led_start pulse
// WAIT  | waiting for led_done, timeout running
// LATCH | line idle for LATCH_CYCLES, then frame_done
module led_frame_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 14,
  parameter int LATCH_CYCLES = 3000,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  led_frame_sequencer_if.master bus
);

  localparam int TMR_MAX = (LATCH_CYCLES > DONE_TIMEOUT) ? LATCH_CYCLES : DONE_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS + 1) : 1;
  localparam logic [TMR_W-1:0] TO_LOAD    = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [15:0]        r_hi;
  logic [PIXEL_W-1:0] r_led_rgb;
  logic               r_err;
  logic [PIXEL_W-1:0] w_pix;
  logic               w_last;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_dec;
  logic               w_tmr_zero;
  logic [7:0]         w_unused_rdata_hi;

  assign w_unused_rdata_hi = bus.mem_rdata[15:8];
  assign w_last            = (r_cnt == CNT_W'(NUM_LEDS - 1));

`ifdef LEDSEQ_DIM_EN
  logic [7:0] r_bright;

  assign w_pix = {scale_chan(r_hi[15:8], r_bright),
                  scale_chan(r_hi[7:0], r_bright),
                  scale_chan(bus.mem_rdata[7:0], r_bright)};
`else
  assign w_pix = {r_hi, bus.mem_rdata[7:0]};
`endif

  led_seq_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    w_tmr_dec  = 1'b0;
    case (r_state)
      IDLE:  if (bus.frame_req) w_next = RD0;
      RD0:   w_next = CAP0;
      CAP0:  w_next = RD1;
      RD1:   w_next = CAP1;
      CAP1:  w_next = SEND;
      SEND: begin
        w_next     = WAIT;
        w_tmr_load = 1'b1;
        w_tmr_val  = TO_LOAD;
      end
      WAIT: begin
        // led_done wins over a timeout expiring in the same cycle
        if (bus.led_done) begin
          if (w_last) begin
            w_next     = LATCH;
            w_tmr_load = 1'b1;
            w_tmr_val  = LATCH_LOAD;
          end else begin
            w_next = RD0;
          end
        end else if (w_tmr_zero) begin
          w_next = IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      LATCH: begin
        if (w_tmr_zero) w_next = IDLE;
        else            w_tmr_dec = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // mem_addr only moves on the edge into RD0/RD1, so it holds through CAPx
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_hi       <= '0;
      r_led_rgb  <= '0;
      r_err      <= 1'b0;
`ifdef LEDSEQ_DIM_EN
      r_bright   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.frame_req) begin
            r_mem_addr <= bus.frame_base;
            r_cnt      <= '0;
            r_err      <= 1'b0;
`ifdef LEDSEQ_DIM_EN
            r_bright   <= bus.brightness;
`endif
          end
        end
        CAP0: begin
          r_hi       <= bus.mem_rdata;
          r_mem_addr <= r_mem_addr + ADDR_W'(1);
        end
        CAP1: r_led_rgb <= w_pix;
        WAIT: begin
          if (bus.led_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (!w_last) r_mem_addr <= r_mem_addr + ADDR_W'(1);
          end else if (w_tmr_zero) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_rd_en  = (r_state == RD0) || (r_state == RD1);
  assign bus.led_start  = (r_state == SEND);
  assign bus.led_rgb    = r_led_rgb;
  assign bus.frame_err  = r_err;
  assign bus.frame_done = (r_state == LATCH) && w_tmr_zero;
  assign bus.frame_busy = (r_state != IDLE) && !bus.frame_done;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer: SPRAM model, randomized
// led_driver model and a frame-level reference model. Honors LEDSEQ_DIM_EN.
module tb_led_frame_sequencer;

  localparam int NUM   = 2;
  localparam int AW    = 14;
  localparam int LATCH = 20;
  localparam int TMO   = 16;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  led_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  led_frame_sequencer #(
    .NUM_LEDS     (NUM),
    .ADDR_W       (AW),
    .LATCH_CYCLES (LATCH),
    .DONE_TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] ram [DEPTH];
  int          q_start_cyc [$];
  logic [23:0] q_start_rgb [$];
  int          q_rd [$];
  int          q_done [$];
  int          q_fd [$];
  int          viol = 0;
  logic [23:0] prev_rgb = '0;
  int          drv_delay = 0;
  int          drv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];

  // driver model: led_done drv_delay cycles after led_start, never if 0
  initial begin
    bus.led_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.led_done = 1'b0;
      if (reset) drv_cnt = 0;
      else if (drv_cnt > 0) begin
        drv_cnt--;
        if (drv_cnt == 0) bus.led_done = 1'b1;
      end else if (bus.led_start && drv_delay > 0) drv_cnt = drv_delay;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) prev_rgb = 24'h0;
      else begin
        if (bus.mem_rd_en) q_rd.push_back(int'(bus.mem_addr));
        if (bus.led_start) begin
          q_start_cyc.push_back(cyc);
          q_start_rgb.push_back(bus.led_rgb);
          prev_rgb = bus.led_rgb;
        end else if (bus.led_rgb !== prev_rgb) viol++;
        if (bus.led_done && bus.frame_busy) q_done.push_back(cyc);
        if (bus.frame_done) q_fd.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference pixel: two words at base+2i, channel scaling c*(br+1)/256
  function automatic logic [23:0] exp_pix(input int base, input int i, input int br);
    int a0, a1, r, g, b;
    a0 = (base + 2 * i) % DEPTH;
    a1 = (a0 + 1) % DEPTH;
    r  = int'(ram[a0][15:8]) * (br + 1) / 256;
    g  = int'(ram[a0][7:0]) * (br + 1) / 256;
    b  = int'(ram[a1][7:0]) * (br + 1) / 256;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic clear_q();
    q_start_cyc.delete();
    q_start_rgb.delete();
    q_rd.delete();
    q_done.delete();
    q_fd.delete();
    viol = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.frame_busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_start"}, 32'(bus.led_start), 32'd0);
    chk({tag, "_rgb"}, 32'(bus.led_rgb), 32'd0);
  endtask

  task automatic issue_req(input int base, input int br, output int req_cyc);
    @(negedge clk);
    bus.frame_req  = 1'b1;
    bus.frame_base = AW'(base);
`ifdef LEDSEQ_DIM_EN
    bus.brightness = 8'(br);
`endif
    req_cyc = cyc;
    @(negedge clk);
    bus.frame_req  = 1'b0;
    bus.frame_base = AW'($urandom);
`ifdef LEDSEQ_DIM_EN
    bus.brightness = 8'($urandom);
`endif
  endtask

  task automatic run_frame(input string nm, input int base, input int dly, input int br,
                           input bit midreq, input bit fill);
    int req_cyc, k, last;
    if (fill) for (int j = 0; j < 2 * NUM; j++) ram[(base + j) % DEPTH] = 16'($urandom);
    clear_q();
    drv_delay = dly;
    issue_req(base, br, req_cyc);
    chk({nm, "_busy_acc"}, 32'(bus.frame_busy), 32'd1);
    chk({nm, "_err_clr"}, 32'(bus.frame_err), 32'd0);
    k = 0;
    while (bus.frame_busy && k < 3000) begin
      @(negedge clk);
      k++;
      if (midreq) bus.frame_req = (k == 8);
    end
    bus.frame_req = 1'b0;
    chk({nm, "_end_busy"}, 32'(bus.frame_busy), 32'd0);
    chk({nm, "_done_at_end"}, 32'(bus.frame_done), 32'd1);
    repeat (2) @(negedge clk);
    chk({nm, "_n_start"}, 32'(q_start_cyc.size()), 32'(NUM));
    for (int i = 0; i < NUM; i++) begin
      if (i < q_start_cyc.size()) begin
        chk($sformatf("%s_rgb%0d", nm, i), 32'(q_start_rgb[i]), 32'(exp_pix(base, i, br)));
        if (i == 0) chk($sformatf("%s_lat%0d", nm, i), 32'(q_start_cyc[i]), 32'(req_cyc + 5));
        else if (i - 1 < q_done.size())
          chk($sformatf("%s_lat%0d", nm, i), 32'(q_start_cyc[i]), 32'(q_done[i-1] + 5));
      end
    end
    chk({nm, "_n_rd"}, 32'(q_rd.size()), 32'(2 * NUM));
    for (int j = 0; j < 2 * NUM; j++)
      if (j < q_rd.size()) chk($sformatf("%s_addr%0d", nm, j), 32'(q_rd[j]), 32'((base + j) % DEPTH));
    chk({nm, "_n_fd"}, 32'(q_fd.size()), 32'd1);
    last = (q_done.size() > 0) ? q_done[q_done.size()-1] : 0;
    if (q_fd.size() > 0) chk({nm, "_fd_lat"}, 32'(q_fd[0]), 32'(last + LATCH));
    chk({nm, "_err"}, 32'(bus.frame_err), 32'd0);
    chk({nm, "_rgb_hold"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int req_cyc, k, s, br;
    bus.frame_req  = 1'b0;
    bus.frame_base = '0;
`ifdef LEDSEQ_DIM_EN
    bus.brightness = 8'hFF;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;

    ram[16'h10] = 16'hA1B2;
    ram[16'h11] = 16'h00C3;
    ram[16'h12] = 16'h1122;
    ram[16'h13] = 16'hFF33;
    run_frame("dir", 16'h10, 3, 255, 1'b0, 1'b0);
    if (q_start_rgb.size() == 2) begin
      chk("dir_px0_const", 32'(q_start_rgb[0]), 32'h00A1B2C3);
      chk("dir_px1_const", 32'(q_start_rgb[1]), 32'h00112233);
    end

    run_frame("wrap", 16'h3FFF, 2, 255, 1'b0, 1'b1);
    if (q_rd.size() > 1) chk("wrap_a1_zero", 32'(q_rd[1]), 32'h0);

    run_frame("midreq", int'($urandom_range(0, DEPTH - 1)), 5, 255, 1'b1, 1'b1);

    for (int n = 0; n < 4; n++) begin
`ifdef LEDSEQ_DIM_EN
      br = int'($urandom_range(0, 255));
`else
      br = 255;
`endif
      run_frame($sformatf("rnd%0d", n), int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(1, 10)), br, 1'b0, 1'b1);
    end

    // driver never answers: timeout on the 16th WAIT cycle of pixel 0
    for (int j = 0; j < 2 * NUM; j++) ram[(100 + j) % DEPTH] = 16'($urandom);
    clear_q();
    drv_delay = 0;
    issue_req(100, 255, req_cyc);
    k = 0;
    while (q_start_cyc.size() == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_start_seen", 32'(q_start_cyc.size()), 32'd1);
    s = (q_start_cyc.size() > 0) ? q_start_cyc[0] : cyc;
    while (cyc < s + TMO && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_last_wait_busy", 32'(bus.frame_busy), 32'd1);
    chk("tmo_last_wait_err", 32'(bus.frame_err), 32'd0);
    @(negedge clk);
    chk("tmo_idle_busy", 32'(bus.frame_busy), 32'd0);
    chk("tmo_err_set", 32'(bus.frame_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("tmo_err_sticky", 32'(bus.frame_err), 32'd1);
    chk("tmo_no_fd", 32'(q_fd.size()), 32'd0);
    chk("tmo_one_start", 32'(q_start_cyc.size()), 32'd1);

    run_frame("after_tmo", int'($urandom_range(0, DEPTH - 1)), 4, 255, 1'b0, 1'b1);

    // reset during WAIT of pixel 1
    for (int j = 0; j < 2 * NUM; j++) ram[(200 + j) % DEPTH] = 16'($urandom);
    clear_q();
    drv_delay = 9;
    issue_req(200, 255, req_cyc);
    k = 0;
    while (q_start_cyc.size() < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rstmid_px1_seen", 32'(q_start_cyc.size()), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rstmid");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_no_fd", 32'(q_fd.size()), 32'd0);
    run_frame("after_rst", 200, 6, 255, 1'b0, 1'b0);

`ifdef LEDSEQ_DIM_EN
    ram[300] = 16'hFF80;
    ram[301] = 16'h5501;
    ram[302] = 16'h1234;
    ram[303] = 16'h0056;
    run_frame("dim7f", 300, 2, 8'h7F, 1'b0, 1'b0);
    if (q_start_rgb.size() > 0) chk("dim7f_const", 32'(q_start_rgb[0]), 32'h007F4000);
    run_frame("dimff", 300, 2, 8'hFF, 1'b0, 1'b0);
    if (q_start_rgb.size() > 0) chk("dimff_const", 32'(q_start_rgb[0]), 32'h00FF8001);
    run_frame("dim00", 300, 2, 8'h00, 1'b0, 1'b0);
    if (q_start_rgb.size() > 0) chk("dim00_const", 32'(q_start_rgb[0]), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
